// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I core front end.
package core_pkg;

   // Canonical RV32I no-op (addi x0, x0, 0), shown on the decode port out of reset.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Fetch FSM: idle, awaiting a live response, or awaiting a response to throw away.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } fetch_state_t;

   // One buffered instruction together with its address and fall-through address.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
   } fetch_entry_t;

   localparam fetch_entry_t NOP_ENTRY = '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0};

endpackage

// File: rtl/pc_adder.sv
// Sequential-address adder: base + 4, modulo 2^32.
module pc_adder (
   input  logic [31:0] base,
   output logic [31:0] sum
);

   assign sum = base + 32'd4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, keeps at most one request in
// flight to instruction memory, buffers up to two returned instructions and
// hands them to decode. A redirect reloads the PC and flushes everything.
module fetch_unit
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   input  logic        id_ready
);

   fetch_state_t state, state_nxt;
   logic [31:0]  pc, pc_plus4;
   logic [31:0]  tag, tag_plus4;
   fetch_entry_t q0, q1, entry_in;
   logic [1:0]   occ;
   logic [2:0]   occ_eff;
   logic         drain, fill, pending, accept, push;

   pc_adder u_pc_inc  (.base(pc),  .sum(pc_plus4));
   pc_adder u_tag_inc (.base(tag), .sum(tag_plus4));

   assign imem_req_addr = pc;
   assign entry_in      = '{instr: imem_rsp_data, pc: tag, pc_plus4: tag_plus4};

   // The head entry is registered, so no input reaches the decode port combinationally.
   assign id_valid    = (occ != 2'd0);
   assign id_instr    = q0.instr;
   assign id_pc       = q0.pc;
   assign id_pc_plus4 = q0.pc_plus4;

   // FSM outputs: request issue and queue fill/drain strobes for this cycle.
   always_comb begin
      drain   = id_valid && id_ready && !redirect_valid;
      fill    = imem_rsp_valid && (state == S_WAIT);
      pending = (state != S_IDLE) && !imem_rsp_valid;
      occ_eff = {1'b0, occ} - {2'b00, drain} + {2'b00, fill};
      // A still-pending request blocks issue outright: only one may be in flight,
      // and with that gate the occupancy-plus-pending bound reduces to occ_eff < 2.
      imem_req_valid = rst_n && !redirect_valid && !pending && (occ_eff < 3'd2);
      accept = imem_req_valid && imem_req_ready;
      push   = fill && !redirect_valid;
   end

   // Next-state: a returning response retires the request; redirect turns a live wait into a drop.
   always_comb begin
      // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = S_WAIT;
         S_WAIT, S_DROP: begin
            if (imem_rsp_valid)      state_nxt = accept ? S_WAIT : S_IDLE;
            else if (redirect_valid) state_nxt = S_DROP;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Fetch pointer and request tag: redirect wins, otherwise advance on acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc  <= RESET_PC;
         tag <= RESET_PC;
      end else if (redirect_valid) begin
         pc <= redirect_pc;
      end else if (accept) begin
         pc  <= pc_plus4;
         tag <= pc;
      end
   end

   // Two-entry shift queue; q0 is always the head, simultaneous push/pop keeps order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: queue storage is reset because the head is visible on the decode port out of reset.
         q0  <= NOP_ENTRY;
         q1  <= NOP_ENTRY;
         occ <= 2'd0;
      end else if (redirect_valid) begin
         occ <= 2'd0;
      end else begin
         case ({push, drain})
            2'b10: begin
               if (occ == 2'd0) q0 <= entry_in;
               else             q1 <= entry_in;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               q0  <= q1;
               occ <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  q0 <= entry_in;
               end else begin
                  q0 <= q1;
                  q1 <= entry_in;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
